// File: rtl/pwm_duty_capture_pkg.sv
// rtl/pwm_duty_capture_pkg.sv - shared state encoding and derived constants for PWM duty capture
package pwm_duty_capture_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_ACQUIRE = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_STUCK   = 2'd2;

    // Default duty width, matching the 8-bit compare counter of the LED PWM generator
    localparam int DEF_CNT_W       = 8;
    localparam int DEF_PWM_PERIOD  = 1 << DEF_CNT_W;
    localparam int DEF_STUCK_LIMIT = 2 * DEF_PWM_PERIOD;

    // Nominal PWM period in ticks for a given duty width
    function automatic int pwm_period(input int cnt_w);
        return 1 << cnt_w;
    endfunction

    // Ticks without a rising edge before the input is declared constant
    function automatic int stuck_limit(input int cnt_w);
        return 2 * pwm_period(cnt_w);
    endfunction

    // Measurement counters carry two extra bits so long periods saturate instead of wrapping
    function automatic int cnt_width(input int cnt_w);
        return cnt_w + 2;
    endfunction

endpackage

// File: rtl/pwm_duty_capture_pwm_in_sync.sv
// rtl/pwm_duty_capture_pwm_in_sync.sv - PWM input synchronizer with rising-edge detect
// Ports:
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset
//   i_pwm    raw PWM input, asynchronous to i_clk
//   o_sync   synchronized level, aligned with o_rise
//   o_rise   one-cycle pulse on each synchronized 0->1 transition
module pwm_in_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pwm,
    output logic o_sync,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_rise;

    // The rise flag is registered alongside the previous-value flop so that the
    // level presented on o_sync is already high in the cycle o_rise fires; the
    // high-time counter then counts the rising-edge tick as high.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_meta <= i_pwm;
            r_sync <= r_meta;
            r_prev <= r_sync;
            r_rise <= r_sync & ~r_prev;
        end
    end

    assign o_sync = r_prev;
    assign o_rise = r_rise;

endmodule

// File: rtl/pwm_duty_capture.sv
// rtl/pwm_duty_capture.sv - recovers the duty word of a PWM waveform by measuring high time and period
// Ports:
//   i_clk          system clock
//   i_rst_n        asynchronous active-low reset
//   i_pwm_in       PWM waveform, asynchronous to i_clk
//   o_duty_out     last recovered duty word
//   o_duty_valid   one-cycle pulse when o_duty_out is updated
//   o_locked       high while o_duty_out reflects a currently valid input
//   o_period_err   one-cycle pulse when a measured period is out of tolerance
module pwm_duty_capture
    import pwm_duty_capture_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int PRESCALE = 1,
    parameter int TOL      = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_pwm_in,
    output logic [CNT_W-1:0] o_duty_out,
    output logic             o_duty_valid,
    output logic             o_locked,
    output logic             o_period_err
);

    localparam int CW          = cnt_width(CNT_W);
    localparam int PWM_PERIOD  = pwm_period(CNT_W);
    localparam int STUCK_LIMIT = stuck_limit(CNT_W);

    localparam logic [CW-1:0] C_MAX        = '1;
    localparam logic [CW-1:0] C_PER_LO     = CW'(PWM_PERIOD - TOL);
    localparam logic [CW-1:0] C_PER_HI     = CW'(PWM_PERIOD + TOL);
    localparam logic [CW-1:0] C_DUTY_MAX   = CW'(PWM_PERIOD - 1);
    localparam logic [CW-1:0] C_IDLE_LAST  = CW'(STUCK_LIMIT - 1);

    logic w_sync;
    logic w_rise;
    logic w_tick;
    logic w_per_ok;
    logic w_stuck_hit;
    logic [CNT_W-1:0] w_hi_sat;

    logic [1:0]       r_state;
    logic [CW-1:0]    r_per_cnt;
    logic [CW-1:0]    r_hi_cnt;
    logic [CW-1:0]    r_idle_cnt;
    logic [CNT_W-1:0] r_duty_out;
    logic             r_duty_valid;
    logic             r_locked;
    logic             r_period_err;

    pwm_in_sync u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_pwm   (i_pwm_in),
        .o_sync  (w_sync),
        .o_rise  (w_rise)
    );

    generate
        if (PRESCALE > 1) begin : g_prescale
            localparam int PW = $clog2(PRESCALE);
            localparam logic [PW-1:0] C_PRE_LAST = PW'(PRESCALE - 1);
            logic [PW-1:0] r_pre_cnt;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_pre_cnt <= '0;
                end else if (r_pre_cnt == C_PRE_LAST) begin
                    r_pre_cnt <= '0;
                end else begin
                    r_pre_cnt <= r_pre_cnt + PW'(1);
                end
            end

            assign w_tick = (r_pre_cnt == C_PRE_LAST);
        end else begin : g_no_prescale
            assign w_tick = 1'b1;
        end
    endgenerate

    assign w_per_ok = (r_per_cnt >= C_PER_LO) && (r_per_cnt <= C_PER_HI);

    // A period stretched with a long high phase can count past the largest duty word
    assign w_hi_sat = (r_hi_cnt > C_DUTY_MAX) ? {CNT_W{1'b1}} : r_hi_cnt[CNT_W-1:0];

    // Fires on the tick that brings idle_cnt up to the limit; saturation keeps it one-shot
    assign w_stuck_hit = w_tick && (r_idle_cnt == C_IDLE_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_per_cnt  <= '0;
            r_hi_cnt   <= '0;
            r_idle_cnt <= '0;
        end else if (w_rise) begin
            // The rising-edge tick is the first tick of the new period and is high
            r_per_cnt  <= CW'(1);
            r_hi_cnt   <= CW'(1);
            r_idle_cnt <= '0;
        end else if (w_tick) begin
            if (r_per_cnt != C_MAX) begin
                r_per_cnt <= r_per_cnt + CW'(1);
            end
            if (w_sync && (r_hi_cnt != C_MAX)) begin
                r_hi_cnt <= r_hi_cnt + CW'(1);
            end
            if (r_idle_cnt != C_MAX) begin
                r_idle_cnt <= r_idle_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_ACQUIRE;
            r_duty_out   <= '0;
            r_duty_valid <= 1'b0;
            r_locked     <= 1'b0;
            r_period_err <= 1'b0;
        end else begin
            r_duty_valid <= 1'b0;
            r_period_err <= 1'b0;
            case (r_state)
                ST_ACQUIRE: begin
                    // The period in progress at start-up is partial, so it is discarded
                    if (w_rise) begin
                        r_state <= ST_MEASURE;
                    end else if (w_stuck_hit) begin
                        r_state      <= ST_STUCK;
                        r_duty_out   <= w_sync ? {CNT_W{1'b1}} : '0;
                        r_duty_valid <= 1'b1;
                        r_locked     <= 1'b1;
                    end
                end
                ST_MEASURE: begin
                    // Rise is checked first so it wins over a coincident idle timeout
                    if (w_rise) begin
                        if (w_per_ok) begin
                            r_duty_out   <= w_hi_sat;
                            r_duty_valid <= 1'b1;
                            r_locked     <= 1'b1;
                        end else begin
                            r_period_err <= 1'b1;
                            r_locked     <= 1'b0;
                        end
                    end else if (w_stuck_hit) begin
                        r_state      <= ST_STUCK;
                        r_duty_out   <= w_sync ? {CNT_W{1'b1}} : '0;
                        r_duty_valid <= 1'b1;
                        r_locked     <= 1'b1;
                    end
                end
                ST_STUCK: begin
                    // The stuck level is no longer current once an edge appears
                    if (w_rise) begin
                        r_state  <= ST_MEASURE;
                        r_locked <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_ACQUIRE;
                end
            endcase
        end
    end

    assign o_duty_out   = r_duty_out;
    assign o_duty_valid = r_duty_valid;
    assign o_locked     = r_locked;
    assign o_period_err = r_period_err;

endmodule

// File: tb/tb_pwm_duty_capture.sv
// tb/tb_pwm_duty_capture.sv - self-checking bench for pwm_duty_capture
module tb_pwm_duty_capture;

    logic       clk;
    logic       rst_n;
    logic       pwm;
    logic [7:0] duty_out;
    logic       duty_valid;
    logic       locked;
    logic       period_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit         is_err;
        logic [7:0] duty;
    } ev_t;

    typedef struct {
        int hi;
        int per;
        int n;
        bit ev_err;
        int ev_duty;
        bit exp_locked;
        int exp_duty_out;
    } vec_t;

    ev_t  evq[$];
    vec_t tbl[11];

    pwm_duty_capture #(
        .CNT_W    (8),
        .PRESCALE (1),
        .TOL      (2)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_pwm_in     (pwm),
        .o_duty_out   (duty_out),
        .o_duty_valid (duty_valid),
        .o_locked     (locked),
        .o_period_err (period_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (duty_valid) evq.push_back('{1'b0, duty_out});
        if (period_err) evq.push_back('{1'b1, 8'd0});
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic drive_period(input int hi, input int per);
        for (int c = 0; c < per; c++) begin
            pwm = (c < hi);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        evq.delete();
    endtask

    task automatic chk_event(input string nm, input bit is_err, input int duty);
        ev_t e;
        if (evq.size() == 0) begin
            chk({nm, "_present"}, 0, 1);
        end else begin
            e = evq.pop_front();
            chk({nm, "_kind"}, int'(e.is_err), int'(is_err));
            if (!is_err) chk({nm, "_duty"}, int'(e.duty), duty);
        end
    endtask

    initial begin
        int n;
        ev_t exp_q[$];
        ev_t e;

        pwm   = 1'b0;
        rst_n = 1'b0;

        //           hi   per  n  err duty lock dout
        tbl[0]  = '{128, 256, 3, 0, 128, 1, 128};
        tbl[1]  = '{255, 256, 3, 0, 255, 1, 255};
        tbl[2]  = '{150, 300, 3, 1,   0, 0, 255};
        tbl[3]  = '{100, 254, 2, 0, 100, 1, 100};
        tbl[4]  = '{ 90, 258, 2, 0,  90, 1,  90};
        tbl[5]  = '{ 64, 256, 2, 0,  64, 1,  64};
        tbl[6]  = '{200, 256, 2, 0, 200, 1, 200};
        tbl[7]  = '{ 80, 259, 2, 1,   0, 0, 200};
        tbl[8]  = '{ 80, 253, 2, 1,   0, 0, 200};
        tbl[9]  = '{128, 256, 2, 0, 128, 1, 128};
        tbl[10] = '{257, 258, 2, 0, 255, 1, 255};

        repeat (2) @(negedge clk);
        #1;
        chk("rst_duty_out", int'(duty_out), 0);
        chk("rst_duty_valid", int'(duty_valid), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_period_err", int'(period_err), 0);
        rst_n = 1'b1;
        evq.delete();

        // Each rise evaluates the period that just ended; the first rise after reset yields nothing
        for (int i = 0; i < 11; i++) begin
            exp_q.delete();
            if (i > 0) exp_q.push_back('{tbl[i-1].ev_err, 8'(tbl[i-1].ev_duty)});
            for (int k = 1; k < tbl[i].n; k++) exp_q.push_back('{tbl[i].ev_err, 8'(tbl[i].ev_duty)});
            for (int k = 0; k < tbl[i].n; k++) drive_period(tbl[i].hi, tbl[i].per);
            #1;
            chk($sformatf("vec%0d_events", i), evq.size(), exp_q.size());
            foreach (exp_q[j]) begin
                e = exp_q[j];
                chk_event($sformatf("vec%0d_ev%0d", i, j), e.is_err, int'(e.duty));
            end
            evq.delete();
            chk($sformatf("vec%0d_locked", i), int'(locked), int'(tbl[i].exp_locked));
            chk($sformatf("vec%0d_duty_out", i), int'(duty_out), tbl[i].exp_duty_out);
        end

        // Reset in the low phase of a period while locked at 128
        drive_period(128, 256);
        drive_period(128, 256);
        #1;
        chk("pre_rst_locked", int'(locked), 1);
        chk("pre_rst_duty", int'(duty_out), 128);
        for (int c = 0; c < 200; c++) begin
            pwm = (c < 128);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_duty_out", int'(duty_out), 0);
        chk("midrst_locked", int'(locked), 0);
        chk("midrst_valid", int'(duty_valid), 0);
        chk("midrst_err", int'(period_err), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        evq.delete();
        repeat (50) @(negedge clk);
        drive_period(128, 256);
        #1;
        chk("midrst_first_rise_events", evq.size(), 0);
        chk("midrst_first_rise_locked", int'(locked), 0);
        drive_period(128, 256);
        #1;
        chk("midrst_second_rise_events", evq.size(), 1);
        chk_event("midrst_second_rise", 1'b0, 128);
        chk("midrst_second_rise_locked", int'(locked), 1);
        evq.delete();

        // Constant low from reset: stuck after exactly 512 ticks without a rise
        pwm = 1'b0;
        do_reset();
        n = 0;
        for (int c = 1; c <= 700; c++) begin
            @(negedge clk);
            if (duty_valid) begin
                n = c;
                break;
            end
        end
        chk("stuck_low_latency", n, 512);
        chk("stuck_low_duty", int'(duty_out), 0);
        chk("stuck_low_locked", int'(locked), 1);
        repeat (600) @(negedge clk);
        #1;
        chk("stuck_low_pulses", evq.size(), 1);
        chk_event("stuck_low_ev", 1'b0, 0);
        evq.delete();
        drive_period(128, 256);
        #1;
        chk("unstuck_locked", int'(locked), 0);
        chk("unstuck_events", evq.size(), 0);
        drive_period(128, 256);
        #1;
        chk("unstuck_events2", evq.size(), 1);
        chk_event("unstuck_ev", 1'b0, 128);
        chk("unstuck_locked2", int'(locked), 1);
        evq.delete();

        // Constant high while measuring: last period reported, then stuck at full scale
        pwm = 1'b1;
        repeat (600) @(negedge clk);
        #1;
        chk("stuck_high_events", evq.size(), 2);
        chk_event("stuck_high_ev0", 1'b0, 128);
        chk_event("stuck_high_ev1", 1'b0, 255);
        chk("stuck_high_locked", int'(locked), 1);
        chk("stuck_high_duty", int'(duty_out), 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_duty_capture.md
Name: pwm_duty_capture

Overview:
- Receive-side counterpart of the RGB LED PWM generator: samples a single-bit PWM waveform and recovers the 8-bit duty word that produced it.
- Used for loopback self-test of the LED peripheral and for reading external PWM sources into the MCU.
- Measures high time and period between rising edges, validates the period, and publishes the duty with a one-cycle valid strobe.
- Constant-level inputs are detected by timeout.

Parameters:
- CNT_W, 8: duty width. Nominal PWM period is 2**CNT_W ticks, matching the generator's free-running 8-bit compare counter.
- PRESCALE, 1: CLK cycles per measurement tick. Must be ≥1; 1 means every CLK is a tick.
- TOL, 2: accepted period deviation in ticks, ±.

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous, active-low reset
- PWM_IN  in  1  PWM waveform; asynchronous to CLK
- DUTY_OUT  out  CNT_W  last recovered duty
- DUTY_VALID  out  1  one-CLK pulse when DUTY_OUT is updated
- LOCKED  out  1  high while DUTY_OUT reflects a currently valid input
- PERIOD_ERR  out  1  one-CLK pulse when a period fails the tolerance check

Behaviour:
- Reset (RST_N=0, asynchronous) clears everything:
  - DUTY_OUT=0, DUTY_VALID=0, LOCKED=0, PERIOD_ERR=0.
  - Synchronizer flops = 0, counters = 0, state = ACQUIRE.
- Input conditioning: 2-flop synchronizer plus a previous-value flop.
  - rise = sync & ~prev.
  - Latency: DUTY_VALID asserts on the 3rd CLK edge after the edge that first samples PWM_IN high.
- Tick: when PRESCALE>1, a prescale counter generates tick_en; otherwise tick_en=1.
- Counters, CNT_W+2 bits each, saturating, advance on tick_en:
  - per_cnt increments every tick.
  - hi_cnt increments when sync=1.
  - On rise, both restart at 1 (the rising-edge tick counts as high).
  - idle_cnt counts ticks since the last rise.
- FSM:
  - ACQUIRE: wait for rise, then restart counters and go to MEASURE. No output, since a partial period is discarded.
  - MEASURE: on rise, evaluate the completed period.
    - If |per_cnt − 2**CNT_W| ≤ TOL: DUTY_OUT = min(hi_cnt, 2**CNT_W−1), DUTY_VALID=1, LOCKED=1.
    - Otherwise: PERIOD_ERR=1, LOCKED=0, DUTY_OUT held.
    - Either way, restart counters and stay in MEASURE.
  - Stuck detection (in ACQUIRE or MEASURE): when idle_cnt reaches 2*2**CNT_W ticks, go to STUCK.
    - DUTY_OUT = sync ? 2**CNT_W−1 : 0.
    - DUTY_VALID=1 for one cycle, LOCKED=1.
  - STUCK: on rise, go to MEASURE with counters restarted, LOCKED=0. No output until the next complete period.
- Simultaneous events: rise and the idle limit in the same cycle → rise wins and the stuck path is suppressed.
- Reset mid-period: all state is discarded and the block returns to ACQUIRE.
- Arithmetic: compare per_cnt against constants only; no division. Saturation prevents wrap in long-period or stuck cases.

Decomposition:
- Shared package:
  - State encoding for ACQUIRE/MEASURE/STUCK.
  - Derived constants PWM_PERIOD = 2**CNT_W and STUCK_LIMIT = 2*PWM_PERIOD.
  - Counter width CNT_W+2.
- One sub-module: pwm_in_sync.
  - Contains the 2-flop synchronizer and rise detect.
  - Outputs sync and rise; reset to 0 by RST_N.

Test Plan:
- Generator driven with duty 128, period 256, PRESCALE=1 → no output for the first period; then DUTY_VALID pulses every 256 cycles with DUTY_OUT=128 and LOCKED=1.
- Duty 255 (255 high, 1 low) → DUTY_OUT=255 each period and no PERIOD_ERR.
- Duty 0 (constant low) → after 512 cycles without a rise: DUTY_OUT=0, a single DUTY_VALID pulse, LOCKED=1. Then raising PWM_IN returns the block to MEASURE with LOCKED=0.
- Period stretched to 300 ticks with 150 high → PERIOD_ERR pulse each period, LOCKED=0, DUTY_OUT holds its prior value. Periods of 254 and 258 are accepted.
- Duty stepped 64→200 at a period boundary → consecutive DUTY_VALID pulses report exactly 64 then 200.
- RST_N pulsed low mid-period while locked at 128 → all outputs 0 immediately. First DUTY_VALID (128) appears only at the second rise after release.
